// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 slave controller: burst encodings, response codes and FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ISSUE,
    RD_CAPTURE,
    RD_DATA
  } ctrl_state_t;

endpackage

// File: rtl/axi4_addr_gen.sv
// Next word address of a burst, computed on the unwrapped word address so that
// range checking can see carries past the top of memory.
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] incr;
  logic [AW-1:0] mask;

  // WRAP keeps the bits above the (len+1)-word window and increments inside it
  always_comb begin
    incr = addr + 1'b1;
    mask = AW'(len);
    case (burst)
      INCR:    next_addr = incr;
      WRAP:    next_addr = (addr & ~mask) | (incr & mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_ctrl.sv
// AXI4 slave front end for a single-port word memory; reads and writes share one FSM.
// Optional macro AXI4_RANGE_CHECK_EN: beats whose unwrapped word address >= DEPTH get SLVERR.
//
// state      | meaning
// IDLE       | arbitrate AW/AR, latch burst on handshake
// WR_DATA    | accept W beats, one memory write per beat
// WR_RESP    | hold B response until bready
// RD_ISSUE   | present read address to memory
// RD_CAPTURE | register memory read data
// RD_DATA    | hold R beat until rready
module axi4_slave_ctrl
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DEPTH          = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wlast,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]                axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  // one spare bit so an INCR burst running past the top address is still visible
  localparam int WA = AXI_ADDR_WIDTH - 1;

  ctrl_state_t state, state_nxt;

  logic [WA-1:0]             addr_q, addr_nxt;
  logic [7:0]                len_q, beat_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      prio_wr_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [MEM_ADDR_WIDTH-1:0] word_addr;
  logic grant_w, grant_r, aw_hs, ar_hs, w_hs, r_hs;
  logic last_beat, range_err, beat_err, wlast_err;
  logic unused_ok;

  axi4_addr_gen #(.AW(WA)) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

`ifdef AXI4_RANGE_CHECK_EN
  assign range_err = (addr_q >= WA'(DEPTH));
`else
  assign range_err = 1'b0;
`endif

  assign beat_err  = (burst_q == 2'b11) | range_err;
  assign last_beat = (beat_q == len_q);
  assign wlast_err = (axi_wlast != last_beat);
  assign word_addr = MEM_ADDR_WIDTH'(addr_q % WA'(DEPTH));
  assign grant_w   = axi_awvalid & (prio_wr_q | ~axi_arvalid);
  assign grant_r   = axi_arvalid & (~prio_wr_q | ~axi_awvalid);
  assign aw_hs     = (state == IDLE) & grant_w;
  assign ar_hs     = (state == IDLE) & grant_r;
  assign w_hs      = (state == WR_DATA) & axi_wvalid;
  assign r_hs      = (state == RD_DATA) & axi_rready;
  assign axi_rdata = rdata_q;
  assign unused_ok = ^{axi_awsize, axi_arsize, axi_wstrb, axi_awaddr[1:0], axi_araddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_w)      state_nxt = WR_DATA;
        else if (grant_r) state_nxt = RD_ISSUE;
      end
      WR_DATA:    if (w_hs && last_beat) state_nxt = WR_RESP;
      WR_RESP:    if (axi_bready) state_nxt = IDLE;
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = RD_DATA;
      RD_DATA:    if (r_hs) state_nxt = last_beat ? IDLE : RD_ISSUE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = RESP_OKAY;
    axi_rvalid  = 1'b0;
    axi_rresp   = RESP_OKAY;
    axi_rlast   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        axi_awready = grant_w;
        axi_arready = grant_r;
      end
      WR_DATA: begin
        axi_wready = 1'b1;
        mem_en     = axi_wvalid & ~beat_err;
        mem_we     = axi_wvalid & ~beat_err;
        mem_addr   = word_addr;
        mem_wdata  = axi_wdata;
      end
      WR_RESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      RD_ISSUE: begin
        mem_en   = ~beat_err;
        mem_addr = word_addr;
      end
      RD_DATA: begin
        axi_rvalid = 1'b1;
        axi_rresp  = beat_err ? RESP_SLVERR : RESP_OKAY;
        axi_rlast  = last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      prio_wr_q <= 1'b1;
      rdata_q   <= '0;
    end else begin
      if (aw_hs) begin
        addr_q    <= {1'b0, axi_awaddr[AXI_ADDR_WIDTH-1:2]};
        len_q     <= axi_awlen;
        burst_q   <= axi_awburst;
        beat_q    <= '0;
        err_q     <= 1'b0;
        prio_wr_q <= ~prio_wr_q;
      end else if (ar_hs) begin
        addr_q    <= {1'b0, axi_araddr[AXI_ADDR_WIDTH-1:2]};
        len_q     <= axi_arlen;
        burst_q   <= axi_arburst;
        beat_q    <= '0;
        prio_wr_q <= ~prio_wr_q;
      end else if (w_hs) begin
        err_q  <= err_q | beat_err | wlast_err;
        beat_q <= beat_q + 1'b1;
        addr_q <= addr_nxt;
      end else if (r_hs) begin
        beat_q <= beat_q + 1'b1;
        addr_q <= addr_nxt;
      end
      // errored beats never touched memory, so mem_rdata is stale there
      if (state == RD_CAPTURE) rdata_q <= beat_err ? '0 : mem_rdata;
    end
  end

endmodule
